// File: rtl/mult32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM encoding and default width.
package mult32_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder32_cla.sv
// WIDTH-bit unsigned carry-lookahead adder built from 4-bit lookahead groups,
// with the group carries chained between groups.
module adder32_cla #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = (WIDTH + 3) / 4;
    localparam int WP = NG * 4;

    // Operands are zero-padded to a whole number of groups; padded bits have g=p=0,
    // so the carry out of the top real bit passes through unchanged.
    logic [WP-1:0] a_pad;
    logic [WP-1:0] b_pad;
    logic [WP-1:0] g;
    logic [WP-1:0] p;
    logic [WP:0]   c;
    logic [WP-1:0] sum_pad;

    assign a_pad   = WP'(a);
    assign b_pad   = WP'(b);
    assign g       = a_pad & b_pad;
    assign p       = a_pad ^ b_pad;
    assign c[0]    = cin;
    assign sum_pad = p ^ c[WP-1:0];
    assign sum     = sum_pad[WIDTH-1:0];
    assign cout    = c[WIDTH];

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            localparam int B = 4 * gi;
            logic grp_g;
            logic grp_p;

            assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];
            assign grp_g = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);

            assign c[B+1] = g[B] | (p[B] & c[B]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & c[B]);
            assign c[B+4] = grp_g | (grp_p & c[B]);
        end
    endgenerate

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned multiplier: one shift-add step per clock, WIDTH steps per product.
// The product register doubles as the multiplier shift register.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               accept;
    logic               last_step;

    // Adding zero when the multiplier LSB is clear leaves hi unchanged with no carry.
    assign addend    = prod_q[0] ? mcand_q : '0;
    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    adder32_cla #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a    (prod_q[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        if (accept) begin
            cnt_d   = '0;
            mcand_d = a;
            prod_d  = {{WIDTH{1'b0}}, b};
        end else if (state_q == CALC) begin
            cnt_d  = cnt_q + 1'b1;
            prod_d = {cout, sum, prod_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        busy    = (state_q == CALC);
        done    = (state_q == DONE);
        product = prod_q;
    end

endmodule

// File: tb/tb_mult32_seq.sv
// Directed-vector bench for mult32_seq: stimulus pushes expected products into a
// scoreboard queue, a monitor pops and checks on every done pulse.
module tb_mult32_seq;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        int             acc_edge;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   busy_run = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    mult32_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_run = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", product, e.prod);
                    check("done_latency", 64'(edge_cnt - e.acc_edge), 64'(W));
                    check("busy_cycles", 64'(busy_run), 64'(W));
                end
                busy_run = 0;
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end
    end

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [2*W-1:0] exp);
        exp_t e;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        e.prod = exp;
        e.acc_edge = edge_cnt + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ta;
        b = ~tb_v;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        // Reset with start asserted: outputs must stay at zero.
        start = 1'b1;
        a = 32'd5;
        b = 32'd5;
        repeat (3) @(negedge clk);
        check("rst_product", product, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        issue(32'd3, 32'd5, 64'd15);
        drain(100);
        repeat (5) begin
            @(negedge clk);
            a = $urandom;
            b = $urandom;
        end
        check("idle_hold", product, 64'd15);
        check("idle_done", 64'(done), 64'd0);

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
        drain(100);
        issue(32'h12345678, 32'h0, 64'd0);
        drain(100);
        issue(32'h0, 32'hDEADBEEF, 64'd0);
        drain(100);

        // A start during CALC must be ignored.
        issue(32'd7, 32'd6, 64'd42);
        repeat (8) @(negedge clk);
        a = 32'd2;
        b = 32'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 32'd99;
        b = 32'd77;
        drain(100);

        // Reset mid-CALC aborts with no done pulse.
        issue(32'd9, 32'd9, 64'd81);
        void'(sb.pop_back());
        repeat (13) @(negedge clk);
        check("calc_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_product", product, 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_abort_busy", 64'(busy), 64'd0);
        issue(32'd4, 32'd4, 64'd16);
        drain(100);

        // Start held high through DONE: back-to-back operations.
        @(negedge clk);
        a = 32'd10;
        b = 32'd10;
        start = 1'b1;
        e.prod = 64'd100;
        e.acc_edge = edge_cnt + 1;
        sb.push_back(e);
        e.prod = 64'd121;
        e.acc_edge = edge_cnt + 1 + W + 1;
        sb.push_back(e);
        @(negedge clk);
        a = 32'd11;
        b = 32'd11;
        while (edge_cnt < e.acc_edge) @(negedge clk);
        start = 1'b0;
        a = '0;
        b = '0;
        drain(100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mult32_seq.md
MULT32_SEQ -- requirements
Module: mult32_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; the product is 2*WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a multiply; sampled on clk rising edge.
REQ-005 The block SHALL have port a, input, WIDTH bits, the unsigned multiplicand; sampled only when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits, the unsigned multiplier; sampled only when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an iteration sequence is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking product valid.
REQ-009 The block SHALL have port product, output, 2*WIDTH bits, the registered unsigned result a*b.

Function
REQ-010 The FSM SHALL have states IDLE, CALC and DONE.
REQ-011 In IDLE or DONE, start=1 at an edge SHALL be accepted: load multiplicand register with a, product register with {WIDTH'b0, b}, clear iteration counter, go to CALC.
REQ-012 In IDLE with start=0, the block SHALL stay in IDLE and product SHALL hold its value.
REQ-013 In CALC, each edge SHALL perform one shift-add step: if product[0]=1, hi = product[2W-1:W] + multiplicand with carry-out c, else hi unchanged and c=0; product <= {c, hi, product[W-1:1]}.
REQ-014 The addition SHALL be WIDTH bits wide and unsigned; its carry-out SHALL be kept as the shifted-in MSB, never dropped.
REQ-015 The iteration counter SHALL be clog2(WIDTH)+1 bits wide; after exactly WIDTH CALC steps the FSM SHALL go to DONE.
REQ-016 DONE SHALL last exactly one cycle; without start it SHALL return to IDLE.
REQ-017 busy SHALL be 1 exactly while state is CALC; done SHALL be 1 exactly while state is DONE.
REQ-018 Latency: for start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH (33 cycles after the start edge for WIDTH=32).
REQ-019 While done is high and afterwards, product SHALL equal a*b until the next accepted start.
REQ-020 start while in CALC SHALL be ignored; the operation in progress and its inputs SHALL be unaffected.
REQ-021 start while in DONE SHALL be accepted as in REQ-011; done SHALL still pulse for the finishing operation.
REQ-022 Changes of a or b after acceptance SHALL have no effect on the result.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE, counter 0, multiplicand 0, product 0, busy 0, done 0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-025 No output SHALL glitch to a nonzero value while rst_n is low.

Structure
REQ-026 The state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH SHALL live in the shared processor package/include, not locally.
REQ-027 The adder SHALL be one sub-module instance, adder32_cla (WIDTH-bit carry-lookahead adder with cin=0, sum and cout); no behavioural "+" in mult32_seq.
REQ-028 All state SHALL sit in a single clocked process; next-state and output decode SHALL be separate combinational logic.

Verification
REQ-029 Reset, then a=3, b=5, start one cycle -> busy high for 32 cycles, done pulse 33 cycles after start edge, product=64'd15.
REQ-030 a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 (exercises carry-out on each step).
REQ-031 a=32'h12345678, b=0, then a=0, b=32'hDEADBEEF -> product=0 both times, done timing unchanged.
REQ-032 Start a=7, b=6; at cycle 10 pulse start with a=2, b=2 and change a,b -> ignored, product=64'd42.
REQ-033 Start a=9, b=9; assert rst_n=0 at cycle 15 -> product=0, busy=0 immediately, no done; new start a=4, b=4 -> product=64'd16.
REQ-034 Hold start high through done with a=10, b=10 then a=11, b=11 -> done pulses for 100, next operation begins that edge, next done gives 121.
